// File: rtl/e_mdu.sv
// ---------------------------------------------------------------------------
// e_mdu : multi-cycle multiply/divide unit for the E stage.
//
// Runs mult/multu/div/divu over a fixed latency and holds the results in the
// architectural HI/LO registers. Also services mfhi/mflo (a combinational read
// via mdResult) and mthi/mtlo (a single-edge write, with no busy cycle).
//
// Optional build macro: MDU_MADD_EN
//   defined   -> mdOp 9..12 = madd/maddu/msub/msubu. These accumulate into
//                {hi,lo} and take MULT_CYCLES.
//   undefined -> mdOp 9..12 are no-ops.
//
// Parameters
//   WIDTH        operand and HI/LO width
//   MULT_CYCLES  latency of the multiply class (>=1)
//   DIV_CYCLES   latency of the divide class (>=1)
//
// Ports
//   clk       system clock
//   reset     synchronous, active-high reset
//   start     qualifies mdOp as a new operation this cycle
//   mdOp      operation code:
//               0 none, 1 mult, 2 multu, 3 div, 4 divu,
//               5 mfhi, 6 mflo, 7 mthi, 8 mtlo, 9-12 madd family
//   srcA      rs operand (dividend / multiplicand / mthi-mtlo data)
//   srcB      rt operand (divisor / multiplier)
//   busy      a multi-cycle operation is in flight
//   hi, lo    current HI / LO registers
//   mdResult  hi when mdOp=5, lo when mdOp=6, else 0 (combinational)
// ---------------------------------------------------------------------------
module e_mdu #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       mdOp,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] mdResult
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;
`ifdef MDU_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'd9;
  localparam logic [3:0] OP_MADDU = 4'd10;
  localparam logic [3:0] OP_MSUB  = 4'd11;
  localparam logic [3:0] OP_MSUBU = 4'd12;
`endif

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state_reg,     state_next;
  logic [CNT_W-1:0]   count_reg,     count_next;
  logic [WIDTH-1:0]   hi_reg,        hi_next;
  logic [WIDTH-1:0]   lo_reg,        lo_next;
  logic [WIDTH-1:0]   pendHi_reg,    pendHi_next;
  logic [WIDTH-1:0]   pendLo_reg,    pendLo_next;
  // Cleared for divide-by-zero, so that completion leaves HI/LO untouched.
  logic               pendWrite_reg, pendWrite_next;

  // ---------------- datapath, evaluated on the issuing edge ----------------
  logic [2*WIDTH-1:0] prodSigned;
  logic [2*WIDTH-1:0] prodUnsigned;

  // Both operands are extended to 2*WIDTH explicitly, so the full product is
  // produced with no dependence on expression-width context.
  assign prodSigned   = $signed({{WIDTH{srcA[WIDTH-1]}}, srcA})
                      * $signed({{WIDTH{srcB[WIDTH-1]}}, srcB});
  assign prodUnsigned = {{WIDTH{1'b0}}, srcA} * {{WIDTH{1'b0}}, srcB};

  logic             divByZero;
  logic             sdivOverflow;
  logic [WIDTH-1:0] minNeg;
  logic [WIDTH-1:0] safeBu;
  logic [WIDTH-1:0] safeBs;
  logic [WIDTH-1:0] quotS, remS, quotU, remU;

  assign minNeg       = {1'b1, {(WIDTH-1){1'b0}}};
  assign divByZero    = (srcB == '0);
  assign sdivOverflow = (srcA == minNeg) && (srcB == '1);

  // For MIN / -1, dividing by +1 instead gives exactly the wrapped result
  // (quotient MIN, remainder 0). It also keeps the divider away from the
  // overflowing case.
  assign safeBu = divByZero                  ? WIDTH'(1) : srcB;
  assign safeBs = (divByZero | sdivOverflow) ? WIDTH'(1) : srcB;

  assign quotS = $signed(srcA) / $signed(safeBs);
  assign remS  = $signed(srcA) % $signed(safeBs);
  assign quotU = srcA / safeBu;
  assign remU  = srcA % safeBu;

`ifdef MDU_MADD_EN
  logic [2*WIDTH-1:0] accNow;
  assign accNow = {hi_reg, lo_reg};
`endif

  // ---------------- next-state / next-register logic ----------------
  always_comb begin
    state_next     = state_reg;
    count_next     = count_reg;
    hi_next        = hi_reg;
    lo_next        = lo_reg;
    pendHi_next    = pendHi_reg;
    pendLo_next    = pendLo_reg;
    pendWrite_next = pendWrite_reg;

    case (state_reg)
      IDLE: begin
        if (start) begin
          case (mdOp)
            OP_MULT: begin
              state_next                 = RUN;
              count_next                 = MULT_LOAD;
              {pendHi_next, pendLo_next} = prodSigned;
              pendWrite_next             = 1'b1;
            end
            OP_MULTU: begin
              state_next                 = RUN;
              count_next                 = MULT_LOAD;
              {pendHi_next, pendLo_next} = prodUnsigned;
              pendWrite_next             = 1'b1;
            end
            OP_DIV: begin
              state_next     = RUN;
              count_next     = DIV_LOAD;
              pendHi_next    = remS;
              pendLo_next    = quotS;
              pendWrite_next = !divByZero;
            end
            OP_DIVU: begin
              state_next     = RUN;
              count_next     = DIV_LOAD;
              pendHi_next    = remU;
              pendLo_next    = quotU;
              pendWrite_next = !divByZero;
            end
            OP_MTHI: hi_next = srcA;
            OP_MTLO: lo_next = srcA;
`ifdef MDU_MADD_EN
            // The accumulate uses HI/LO as they stand at the issuing edge.
            OP_MADD: begin
              state_next                 = RUN;
              count_next                 = MULT_LOAD;
              {pendHi_next, pendLo_next} = accNow + prodSigned;
              pendWrite_next             = 1'b1;
            end
            OP_MADDU: begin
              state_next                 = RUN;
              count_next                 = MULT_LOAD;
              {pendHi_next, pendLo_next} = accNow + prodUnsigned;
              pendWrite_next             = 1'b1;
            end
            OP_MSUB: begin
              state_next                 = RUN;
              count_next                 = MULT_LOAD;
              {pendHi_next, pendLo_next} = accNow - prodSigned;
              pendWrite_next             = 1'b1;
            end
            OP_MSUBU: begin
              state_next                 = RUN;
              count_next                 = MULT_LOAD;
              {pendHi_next, pendLo_next} = accNow - prodUnsigned;
              pendWrite_next             = 1'b1;
            end
`endif
            default: ;
          endcase
        end
      end

      RUN: begin
        // Any start seen while running is dropped on purpose.
        count_next = count_reg - CNT_W'(1);
        if (count_reg == CNT_W'(1)) begin
          state_next = IDLE;
          if (pendWrite_reg) begin
            hi_next = pendHi_reg;
            lo_next = pendLo_reg;
          end
        end
      end

      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      count_reg     <= '0;
      hi_reg        <= '0;
      lo_reg        <= '0;
      pendHi_reg    <= '0;
      pendLo_reg    <= '0;
      pendWrite_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      count_reg     <= count_next;
      hi_reg        <= hi_next;
      lo_reg        <= lo_next;
      pendHi_reg    <= pendHi_next;
      pendLo_reg    <= pendLo_next;
      pendWrite_reg <= pendWrite_next;
    end
  end

  // ---------------- outputs ----------------
  assign busy = (state_reg == RUN);
  assign hi   = hi_reg;
  assign lo   = lo_reg;

  always_comb begin
    mdResult = '0;
    case (mdOp)
      OP_MFHI: mdResult = hi_reg;
      OP_MFLO: mdResult = lo_reg;
      default: mdResult = '0;
    endcase
  end

endmodule
